// File: rtl/switch_input_port.sv
// Slide-switch input conditioner: two-flop synchroniser, whole-word debouncer and a
// CPU-facing registered read port with a sticky new-data flag.
module switch_input_port #(
    parameter int unsigned WIDTH           = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic             boardCLK,
    input  logic             reset,
    input  logic [WIDTH-1:0] switches,
    input  logic             rdReq,
    output logic [WIDTH-1:0] rdData,
    output logic             newData,
    output logic             changed,
    output logic [WIDTH-1:0] stableOut
);

    localparam logic [7:0] CntMax = 8'(DEBOUNCE_CYCLES);

    logic [WIDTH-1:0] sync1_q, sync1_d;
    logic [WIDTH-1:0] sync2_q, sync2_d;
    logic [WIDTH-1:0] cand_q, cand_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] stable_q, stable_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic             new_data_q, new_data_d;
    logic             changed_q, changed_d;
    logic             update;

    // A candidate is accepted only once it has saturated the counter and differs from stable.
    assign update = (cnt_q == CntMax) && (cand_q != stable_q);

    always_comb begin
        sync1_d    = switches;
        sync2_d    = sync1_q;
        cand_d     = cand_q;
        cnt_d      = cnt_q;
        stable_d   = stable_q;
        rd_data_d  = rd_data_q;
        new_data_d = new_data_q;
        changed_d  = 1'b0;

        if (sync2_q != cand_q) begin
            cand_d = sync2_q;
            cnt_d  = 8'd0;
        end else if (cnt_q < CntMax) begin
            cnt_d = cnt_q + 8'd1;
        end

        if (rdReq) begin
            rd_data_d  = stable_q;
            new_data_d = 1'b0;
        end

        // An update on the same edge as a read wins, so the fresh value is never lost.
        if (update) begin
            stable_d   = cand_q;
            changed_d  = 1'b1;
            new_data_d = 1'b1;
        end
    end

    always_ff @(posedge boardCLK or negedge reset) begin
        if (!reset) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            cand_q     <= '0;
            cnt_q      <= '0;
            stable_q   <= '0;
            rd_data_q  <= '0;
            new_data_q <= 1'b0;
            changed_q  <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            cand_q     <= cand_d;
            cnt_q      <= cnt_d;
            stable_q   <= stable_d;
            rd_data_q  <= rd_data_d;
            new_data_q <= new_data_d;
            changed_q  <= changed_d;
        end
    end

    assign rdData    = rd_data_q;
    assign newData   = new_data_q;
    assign changed   = changed_q;
    assign stableOut = stable_q;

endmodule

// File: tb/tb_switch_input_port.sv
// Randomised scoreboard bench for switch_input_port: a window-based reference model predicts
// stable updates and read responses; a negedge monitor pops and compares them.
module tb_switch_input_port;

    localparam int unsigned W  = 8;
    localparam int unsigned DC = 4;

    logic         boardCLK = 1'b0;
    logic         reset    = 1'b0;
    logic [W-1:0] switches = '0;
    logic         rdReq    = 1'b0;
    logic [W-1:0] rdData;
    logic         newData;
    logic         changed;
    logic [W-1:0] stableOut;

    switch_input_port #(.WIDTH(W), .DEBOUNCE_CYCLES(DC)) dut (
        .boardCLK (boardCLK),
        .reset    (reset),
        .switches (switches),
        .rdReq    (rdReq),
        .rdData   (rdData),
        .newData  (newData),
        .changed  (changed),
        .stableOut(stableOut)
    );

    always #5 boardCLK = ~boardCLK;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: stable takes value v at edge n when the raw samples presented at
    // edges n-3-DC .. n-3 are all v and v differs from the current stable value.
    // hist holds samples from the reset point on; reset acts as three zero samples.
    logic [W-1:0] hist[$];
    logic [W-1:0] change_q[$];
    logic [W:0]   read_q[$];
    logic [W-1:0] m_stable = '0;
    logic         m_new    = 1'b0;
    logic [W-1:0] s_smp, old_stable;
    logic         rd_smp, all_eq;
    int           hi;

    initial begin
        hist = '{8'h00, 8'h00, 8'h00};
        forever begin
            @(posedge boardCLK or negedge reset);
            if (!reset) begin
                hist = '{8'h00, 8'h00, 8'h00};
                m_stable = '0;
                m_new = 1'b0;
                change_q.delete();
                read_q.delete();
            end else begin
                s_smp = switches;
                rd_smp = rdReq;
                old_stable = m_stable;
                hist.push_back(s_smp);
                if (hist.size() > 40) void'(hist.pop_front());
                hi = hist.size() - 4;
                all_eq = 1'b0;
                if (hist.size() >= DC + 4) begin
                    all_eq = 1'b1;
                    for (int i = hi - int'(DC); i <= hi; i++)
                        if (hist[i] != hist[hi]) all_eq = 1'b0;
                end
                if (all_eq && hist[hi] != m_stable) begin
                    m_stable = hist[hi];
                    m_new = 1'b1;
                    change_q.push_back(m_stable);
                end else if (rd_smp) begin
                    m_new = 1'b0;
                end
                if (rd_smp) read_q.push_back({old_stable, m_new});
            end
        end
    end

    // Monitor: compares DUT outputs away from the active edge.
    logic [W-1:0] exp_chg_val;
    logic [W:0]   exp_rd;
    logic         exp_chg;
    int unsigned  n_changed = 0;
    logic         saw15 = 1'b0;

    initial begin
        forever begin
            @(negedge boardCLK);
            if (reset) begin
                if (changed) n_changed++;
                if (stableOut == 8'h15) saw15 = 1'b1;
                exp_chg = (change_q.size() != 0);
                check("changed", 32'(changed), 32'(exp_chg));
                if (exp_chg) begin
                    exp_chg_val = change_q.pop_front();
                    check("changed_value", 32'(stableOut), 32'(exp_chg_val));
                end
                check("stableOut", 32'(stableOut), 32'(m_stable));
                check("newData", 32'(newData), 32'(m_new));
                if (read_q.size() != 0) begin
                    exp_rd = read_q.pop_front();
                    check("read_rdData", 32'(rdData), 32'(exp_rd[W:1]));
                    check("read_newData", 32'(newData), 32'(exp_rd[0]));
                end
            end
        end
    end

    task automatic do_read();
        rdReq = 1'b1;
        @(negedge boardCLK);
        rdReq = 1'b0;
    endtask

    int unsigned chg_before;
    logic [W-1:0] rv;
    int unsigned len;

    initial begin
        repeat (3) @(negedge boardCLK);

        // Release with 0xF2 held: accepted on the 8th edge after release.
        switches = 8'hF2;
        reset = 1'b1;
        repeat (7) @(negedge boardCLK);
        check("f2_not_yet", 32'(stableOut), 32'(8'h00));
        @(negedge boardCLK);
        check("f2_stable", 32'(stableOut), 32'(8'hF2));
        check("f2_changed", 32'(changed), 32'(1));
        check("f2_newData", 32'(newData), 32'(1));
        check("f2_rdData_unread", 32'(rdData), 32'(8'h00));
        @(negedge boardCLK);
        check("f2_pulse_one_cycle", 32'(changed), 32'(0));

        do_read();
        check("rd1_data", 32'(rdData), 32'(8'hF2));
        check("rd1_newData", 32'(newData), 32'(0));
        do_read();
        check("rd2_data", 32'(rdData), 32'(8'hF2));
        check("rd2_newData", 32'(newData), 32'(0));

        switches = 8'h14;
        repeat (8) @(negedge boardCLK);
        check("x14_stable", 32'(stableOut), 32'(8'h14));
        check("x14_changed", 32'(changed), 32'(1));
        do_read();
        check("x14_read", 32'(rdData), 32'(8'h14));

        // Three-cycle glitch never reaches stable.
        chg_before = n_changed;
        switches = 8'h15;
        repeat (3) @(negedge boardCLK);
        switches = 8'h14;
        repeat (12) @(negedge boardCLK);
        check("glitch_never_stable", 32'(saw15), 32'(0));
        check("glitch_no_pulse", n_changed - chg_before, 32'(0));

        // Read on the exact update edge.
        switches = 8'hAA;
        repeat (7) @(negedge boardCLK);
        do_read();
        check("coinc_rdData_old", 32'(rdData), 32'(8'h14));
        check("coinc_newData_kept", 32'(newData), 32'(1));
        check("coinc_stable", 32'(stableOut), 32'(8'hAA));
        do_read();
        check("coinc_next_read", 32'(rdData), 32'(8'hAA));
        check("coinc_newData_clr", 32'(newData), 32'(0));

        // Async reset mid-count.
        switches = 8'h5C;
        repeat (4) @(negedge boardCLK);
        #2 reset = 1'b0;
        #1;
        check("rst_rdData", 32'(rdData), 32'(0));
        check("rst_newData", 32'(newData), 32'(0));
        check("rst_changed", 32'(changed), 32'(0));
        check("rst_stable", 32'(stableOut), 32'(0));
        @(negedge boardCLK);
        reset = 1'b1;
        repeat (7) @(negedge boardCLK);
        check("post_rst_not_yet", 32'(stableOut), 32'(0));
        @(negedge boardCLK);
        check("post_rst_stable", 32'(stableOut), 32'(8'h5C));
        check("post_rst_changed", 32'(changed), 32'(1));

        // Randomised segments with occasional reads, zero values and resets.
        for (int seg = 0; seg < 300; seg++) begin
            case ($urandom_range(0, 5))
                0: rv = 8'h00;
                1: rv = switches;
                2: rv = switches ^ (8'h01 << $urandom_range(0, 7));
                default: rv = 8'($urandom_range(0, 255));
            endcase
            switches = rv;
            len = $urandom_range(1, 10);
            for (int c = 0; c < int'(len); c++) begin
                rdReq = ($urandom_range(0, 3) == 0);
                @(negedge boardCLK);
            end
            rdReq = 1'b0;
            if ($urandom_range(0, 39) == 0) begin
                #2 reset = 1'b0;
                @(negedge boardCLK);
                @(negedge boardCLK);
                reset = 1'b1;
            end
        end

        rdReq = 1'b0;
        repeat (12) @(negedge boardCLK);
        check("drain_change_q", change_q.size(), 32'(0));
        check("drain_read_q", read_q.size(), 32'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
